// File: rtl/fsk_bit_sequencer.sv
// fsk_bit_sequencer
// Sequences one frame out of an external parallel-load, left-shifting
// register and turns each bit into a binary-FSK square wave.
//
// A frame is accepted through a valid/ready handshake. In the accept cycle
// ld_en_o is pulsed, so the register loads on the same edge. The block then
// spends BIT_CYCLES clocks on each bit, MSB first. While a bit is sent,
// mod_out_o toggles every HALF1 clocks if the bit is 1, or every HALF0 clocks
// if it is 0. Every bit starts with mod_out_o high. At the end of bits
// 0..WIDTH-2, sh_en_o advances the register to the next bit.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active high
//   in_valid_i    source presents a frame on the register's parallel input
//   in_ready_o    block is idle and can accept a frame
//   ser_bit_i     shift-register MSB, the bit currently being sent
//   ld_en_o       load enable to the shift register (accept cycle only)
//   sh_en_o       shift enable to the shift register (last cycle of a bit)
//   mod_out_o     registered FSK output
//   busy_o        high while a frame is being sent
//   frame_done_o  one-cycle pulse in the last cycle of a frame
module fsk_bit_sequencer #(
  parameter int WIDTH      = 9,
  parameter int BIT_CYCLES = 64,
  parameter int HALF0      = 8,
  parameter int HALF1      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  logic ser_bit_i,
  output logic ld_en_o,
  output logic sh_en_o,
  output logic mod_out_o,
  output logic busy_o,
  output logic frame_done_o
);

  localparam int HMAX = (HALF0 > HALF1) ? HALF0 : HALF1;
  localparam int CW   = $clog2(BIT_CYCLES);
  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [HW-1:0] H0_LAST  = HW'(HALF0 - 1);
  localparam logic [HW-1:0] H1_LAST  = HW'(HALF1 - 1);
  localparam logic [CW-1:0] CYC_ONE  = CW'(1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [HW-1:0] HALF_ONE = HW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [HW-1:0] half_q, half_d;
  logic          mod_q, mod_d;

  logic cyc_last;
  logic bit_last;
  logic half_last;

  assign cyc_last  = (cyc_q == CYC_LAST);
  assign bit_last  = (bit_q == BIT_LAST);
  // The half period follows the bit currently on the register output.
  // That output is stable for a whole bit, so the compare target never
  // changes under a running half_q.
  assign half_last = (half_q == (ser_bit_i ? H1_LAST : H0_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      half_q  <= '0;
      mod_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      mod_q   <= mod_d;
    end
  end

  // Outputs are gated with rst so that they read low for the whole time
  // reset is held, not only after the state register has cleared.
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    bit_d        = bit_q;
    half_d       = half_q;
    mod_d        = mod_q;
    in_ready_o   = 1'b0;
    ld_en_o      = 1'b0;
    sh_en_o      = 1'b0;
    busy_o       = 1'b0;
    frame_done_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready_o = ~rst;
        mod_d      = 1'b0;
        if (in_valid_i && !rst) begin
          ld_en_o = 1'b1;
          state_d = SEND;
          cyc_d   = '0;
          bit_d   = '0;
          half_d  = '0;
          mod_d   = 1'b1;
        end
      end

      SEND: begin
        busy_o = ~rst;
        if (cyc_last) begin
          cyc_d  = '0;
          half_d = '0;
          if (bit_last) begin
            frame_done_o = ~rst;
            state_d      = IDLE;
            bit_d        = '0;
            mod_d        = 1'b0;
          end else begin
            // Phase reset: every bit starts on a high level.
            sh_en_o = ~rst;
            bit_d   = bit_q + BIT_ONE;
            mod_d   = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + CYC_ONE;
          if (half_last) begin
            mod_d  = ~mod_q;
            half_d = '0;
          end else begin
            half_d = half_q + HALF_ONE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign mod_out_o = mod_q;

endmodule

// File: tb/tb_fsk_bit_sequencer.sv
module tb_fsk_bit_sequencer;

  localparam int W   = 9;
  localparam int BC  = 16;
  localparam int H0  = 4;
  localparam int H1  = 2;
  localparam int N   = W * BC;

  localparam int W2  = 3;
  localparam int BC2 = 10;
  localparam int H02 = 4;
  localparam int H12 = 3;
  localparam int N2  = W2 * BC2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          in_valid = 1'b0;
  logic [W-1:0]  par_word = '0;
  logic [W-1:0]  sr = '0;
  logic          in_ready, ld_en, sh_en, mod_out, busy, frame_done;

  logic          in_valid2 = 1'b0;
  logic [W2-1:0] par2 = '0;
  logic [W2-1:0] sr2 = '0;
  logic          in_ready2, ld_en2, sh_en2, mod_out2, busy2, frame_done2;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc_n  = 0;
  int last_acc = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) cyc_n <= cyc_n + 1;

  // External shift registers: parallel load, shift left, MSB drives ser_bit.
  always_ff @(posedge clk) begin
    if (ld_en) sr <= par_word;
    else if (sh_en) sr <= sr << 1;
  end

  always_ff @(posedge clk) begin
    if (ld_en2) sr2 <= par2;
    else if (sh_en2) sr2 <= sr2 << 1;
  end

  fsk_bit_sequencer #(.WIDTH(W), .BIT_CYCLES(BC), .HALF0(H0), .HALF1(H1)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .ser_bit_i(sr[W-1]), .ld_en_o(ld_en), .sh_en_o(sh_en), .mod_out_o(mod_out),
    .busy_o(busy), .frame_done_o(frame_done)
  );

  fsk_bit_sequencer #(.WIDTH(W2), .BIT_CYCLES(BC2), .HALF0(H02), .HALF1(H12)) dut2 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .ser_bit_i(sr2[W2-1]), .ld_en_o(ld_en2), .sh_en_o(sh_en2), .mod_out_o(mod_out2),
    .busy_o(busy2), .frame_done_o(frame_done2)
  );

  // Reference: cycle t (1-based) after the accept edge belongs to bit
  // k=(t-1)/bc at offset j=(t-1)%bc; the level is high in even half periods.
  function automatic logic exp_mod(input logic [31:0] word, input int w, input int bc,
                                   input int h0, input int h1, input int t);
    int k, j, h;
    k = (t - 1) / bc;
    j = (t - 1) % bc;
    h = word[w-1-k] ? h1 : h0;
    return ((j / h) % 2) == 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // mode 0: in_valid low during SEND; 1: random in_valid/word noise; 2: in_valid held high
  task automatic run_frame(input logic [W-1:0] w, input int mode, input int stop_at,
                           input bit chk_gap);
    int nsh, nbusy, j, k;
    nsh = 0; nbusy = 0;
    @(negedge clk);
    par_word = w; in_valid = 1'b1;
    #1;
    chk("acc_ready", in_ready, 1);
    chk("acc_ld", ld_en, 1);
    chk("acc_mod", mod_out, 0);
    chk("acc_busy", busy, 0);
    if (chk_gap) chk("b2b_gap", cyc_n - last_acc, N + 1);
    last_acc = cyc_n;
    for (int t = 1; t <= stop_at; t++) begin
      @(negedge clk);
      if (mode == 1) begin
        in_valid = 1'($urandom_range(0, 1));
        par_word = W'($urandom);
      end else if (mode == 0) begin
        in_valid = 1'b0;
      end
      #1;
      j = (t - 1) % BC;
      k = (t - 1) / BC;
      chk("mod", mod_out, exp_mod(32'(w), W, BC, H0, H1, t));
      chk("busy", busy, 1);
      chk("ready_send", in_ready, 0);
      chk("ld_send", ld_en, 0);
      chk("sh_en", sh_en, (j == BC - 1) && (k < W - 1));
      chk("frame_done", frame_done, t == N);
      if (sh_en) nsh++;
      if (busy) nbusy++;
    end
    if (stop_at == N) begin
      chk("sh_count", nsh, W - 1);
      chk("busy_count", nbusy, N);
    end
    if (mode != 2) in_valid = 1'b0;
  endtask

  task automatic check_idle();
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("idle_ready", in_ready, 1);
    chk("idle_mod", mod_out, 0);
    chk("idle_busy", busy, 0);
    chk("idle_sh", sh_en, 0);
    chk("idle_done", frame_done, 0);
    chk("idle_ld", ld_en, 0);
  endtask

  task automatic check_rst_outputs();
    chk("rst_mod", mod_out, 0);
    chk("rst_ld", ld_en, 0);
    chk("rst_sh", sh_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ready", in_ready, 0);
  endtask

  task automatic run_frame2(input logic [W2-1:0] w, input bit literal_zero);
    logic [BC2-1:0] pat;
    int j, k;
    pat = 10'b1111000011;
    @(negedge clk);
    par2 = w; in_valid2 = 1'b1;
    #1;
    chk("d2_ld", ld_en2, 1);
    for (int t = 1; t <= N2; t++) begin
      @(negedge clk);
      in_valid2 = 1'b0;
      #1;
      j = (t - 1) % BC2;
      k = (t - 1) / BC2;
      chk("d2_mod", mod_out2, exp_mod(32'(w), W2, BC2, H02, H12, t));
      if (literal_zero) chk("d2_pat", mod_out2, pat[BC2-1-j]);
      chk("d2_sh", sh_en2, (j == BC2 - 1) && (k < W2 - 1));
      chk("d2_done", frame_done2, t == N2);
    end
    @(negedge clk);
    #1;
    chk("d2_idle_mod", mod_out2, 0);
    chk("d2_idle_ready", in_ready2, 1);
  endtask

  initial begin
    // Reset asserted with arbitrary inputs
    #3;
    in_valid = 1'b1;
    rst = 1'b1;
    #1;
    check_rst_outputs();
    chk("d2_rst_mod", mod_out2, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rel_ready", in_ready, 1);
    chk("rel_mod", mod_out, 0);

    // Single frame, directed word
    run_frame(9'b1_0000_0001, 0, N, 1'b0);
    check_idle();

    // Ignored input during SEND
    run_frame(W'($urandom), 1, N, 1'b0);
    check_idle();

    // Back-to-back with in_valid held high
    run_frame(W'($urandom), 2, N, 1'b0);
    run_frame(W'($urandom), 2, N, 1'b1);
    check_idle();

    // Reset during bit 4
    run_frame(W'($urandom), 0, 4 * BC + 7, 1'b0);
    #1;
    in_valid = 1'b1;
    rst = 1'b1;
    #1;
    check_rst_outputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_hold_sh", sh_en, 0);
      chk("rst_hold_mod", mod_out, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rel2_ready", in_ready, 1);
    chk("rel2_mod", mod_out, 0);
    run_frame(9'h1FF, 0, N, 1'b0);
    check_idle();

    // Random frames with random SEND-time noise
    for (int i = 0; i < 3; i++) begin
      run_frame(W'($urandom), int'($urandom_range(0, 1)), N, 1'b0);
      check_idle();
    end

    // Odd bit/half-period ratio on the second instance
    run_frame2('0, 1'b1);
    run_frame2(W2'($urandom), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fsk_bit_sequencer.md
# fsk_bit_sequencer

Control and modulation stage that sits directly after the 9-bit parallel-load shift register in the digital modulation datapath. It accepts a frame through a valid/ready handshake and pulses the register's load enable. It then walks the register's MSB out one bit at a time using shift-enable pulses. Each bit becomes a binary-FSK square wave on `mod_out`, with the half period chosen by the current bit value.

## Interface
- `WIDTH`, 9, bits per frame; must match the shift register width; ≥2
- `BIT_CYCLES`, 64, clock cycles per transmitted bit; ≥2
- `HALF0`, 8, square-wave half period in clocks while the current bit is 0; ≥1
- `HALF1`, 4, square-wave half period in clocks while the current bit is 1; ≥1

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  source has a frame on the shift register's parallel input
- `in_ready`  out  1  block can accept a frame; `(state==IDLE) & ~rst`
- `ser_bit`  in  1  shift register MSB (current bit being sent)
- `ld_en`  out  1  combinational load enable to the shift register; high only in the accept cycle
- `sh_en`  out  1  combinational shift enable to the shift register
- `mod_out`  out  1  registered FSK output
- `busy`  out  1  high while in SEND
- `frame_done`  out  1  one-cycle pulse in the last SEND cycle of a frame

## Operation
- States are IDLE and SEND. Internal counters:
  - `cyc_cnt` runs 0..BIT_CYCLES-1.
  - `bit_cnt` runs 0..WIDTH-1.
  - `half_cnt` runs 0..max(HALF0,HALF1)-1.
- **IDLE:**
  - `in_ready=1`, `mod_out=0`, `sh_en=0`.
  - Accept happens when `in_valid & in_ready`. In that cycle `ld_en=1`, so the shift register loads on the same edge.
  - On that edge: go to SEND, clear all counters, set `mod_out<=1`.
- **SEND:**
  - `in_ready=0`. `in_valid` is ignored, and `ld_en` stays 0 for the whole state.
  - Every cycle `cyc_cnt` increments. `H` is `HALF1` when `ser_bit=1`, otherwise `HALF0`, sampled each cycle.
  - If `half_cnt==H-1`, toggle `mod_out` and clear `half_cnt`; otherwise increment `half_cnt`.
- **Bit boundary:** when `cyc_cnt==BIT_CYCLES-1` and `bit_cnt<WIDTH-1`:
  - `sh_en=1` that cycle.
  - On the edge: `bit_cnt` increments, and `cyc_cnt` and `half_cnt` clear.
  - `mod_out<=1`, so every bit starts high (phase reset per bit).
- **Frame end:** when `cyc_cnt==BIT_CYCLES-1` and `bit_cnt==WIDTH-1`:
  - `frame_done=1` and `sh_en=0`.
  - Next state IDLE with `mod_out<=0`.
- **Bit order:** MSB first. Bit k sent is `parallelIN[WIDTH-1-k]` of the loaded word. The register shifts left, so `ser_bit` shows the next bit after each `sh_en` edge.
- **Bit-value change:** a change in `H` mid-bit cannot occur in normal use, because the register is stable within a bit.
- **Reset:** async `rst` at any time, including mid-frame, forces:
  - state IDLE, all counters 0, `mod_out=0`
  - `ld_en=sh_en=busy=frame_done=in_ready=0` while `rst` is high.
  - After release, `in_ready=1`. A partially sent frame is discarded, never resumed.

## Timing
- Accept edge E0. SEND occupies cycles E0+1 .. E0+WIDTH·BIT_CYCLES; `busy` is high exactly for these.
- Bit k occupies cycles E0+1+k·BIT_CYCLES .. E0+(k+1)·BIT_CYCLES. `mod_out=1` in the first cycle of every bit.
- `sh_en` pulses WIDTH-1 times, in the last cycle of bits 0..WIDTH-2.
- `frame_done` fires in cycle E0+WIDTH·BIT_CYCLES. `in_ready` returns in the next cycle.
- With `in_valid` held high, the minimum spacing between accepts is WIDTH·BIT_CYCLES+1 cycles, i.e. one IDLE cycle per frame.
- Within a bit, `mod_out` holds for H cycles per level. If `BIT_CYCLES` is not a multiple of H, the final partial level is truncated at the bit boundary.

## Test plan
- **Reset:** assert `rst` mid-operation with arbitrary inputs. Required: `mod_out=0`, `ld_en=sh_en=busy=frame_done=in_ready=0`. After release: `in_ready=1`, `mod_out=0`.
- **Single frame:** `WIDTH=9`, `BIT_CYCLES=16`, `HALF0=4`, `HALF1=2`, word `9'b1_0000_0001`, one-cycle `in_valid`. Required:
  - `ld_en` high only in the accept cycle.
  - Bit 0 pattern `1100110011001100`; bits 1–7 pattern `1111000011110000`; bit 8 pattern `1100110011001100`.
  - 8 `sh_en` pulses, 16 cycles apart.
  - `frame_done` 144 cycles after accept; `busy` high for exactly 144 cycles.
- **Back-to-back:** hold `in_valid` high for two frames. Required: second accept exactly 145 cycles after the first, with one IDLE cycle and `mod_out=0` in that cycle.
- **Ignored input:** pulse `in_valid` repeatedly during SEND. Required: no `ld_en`, frame output unchanged.
- **Reset mid-frame:** assert `rst` during bit 4. Required: `mod_out` drops to 0 immediately and no further `sh_en`. A new frame `9'h1FF` after release transmits all 9 bits at half period 2 with a full 144-cycle frame.
- **Odd ratio:** `BIT_CYCLES=10`, `HALF0=4`, all-zero word. Required: per-bit pattern `1111000011` and `mod_out` re-starting at 1 on each bit boundary.
